// File: rtl/cnn_buf_pkg.sv
// Shared definitions for the ping-pong feature-map buffer: bank encoding,
// the debug view of the bank pointers, and the address-width helper.
package cnn_buf_pkg;

  typedef enum logic {
    BANK_A = 1'b0,
    BANK_B = 1'b1
  } bank_e;

  // Bank pointers grouped so checkers can bind to one signal.
  typedef struct packed {
    bank_e rd_sel;
    bank_e wr_sel;
  } sel_state_t;

  // $clog2 clamped to 1 so a dimension of size 1 still gets a 1-bit port.
  function automatic int clog2_min1(input int v);
    int r;
    r = $clog2(v);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fmap_bank.sv
// One feature-map bank: single write port, registered read port.
// Contents are intentionally not reset.
module fmap_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // o_rdata only moves on a real read, so the top can rely on it holding.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/pingpong_fmap_buffer.sv
// Double-buffered CNN feature-map store: the producer fills one bank while the
// consumer reads the other; banks swap on wr_last commit and rd_done release.
module pingpong_fmap_buffer
  import cnn_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_H      = 64,
  parameter int OUT_W      = 64,
  parameter int OUT_C      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [clog2_min1(OUT_C)-1:0] wr_ch,
  input  logic [clog2_min1(OUT_H)-1:0] wr_h,
  input  logic [clog2_min1(OUT_W)-1:0] wr_w,
  input  logic                         wr_last,
  input  logic                         rd_en,
  input  logic [clog2_min1(OUT_C)-1:0] rd_ch,
  input  logic [clog2_min1(OUT_H)-1:0] rd_h,
  input  logic [clog2_min1(OUT_W)-1:0] rd_w,
  input  logic                         rd_done,
  output logic                         rd_avail,
  output logic                         rd_valid,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic [1:0]                   bank_full,
  output logic                         err_oob
);

  localparam int DEPTH = OUT_C * OUT_H * OUT_W;
  localparam int AW    = clog2_min1(DEPTH);
  localparam logic [AW-1:0] CH_STRIDE  = AW'(OUT_H * OUT_W);
  localparam logic [AW-1:0] ROW_STRIDE = AW'(OUT_W);

  sel_state_t            r_sel;
  logic [1:0]            r_bank_full;
  logic                  r_rd_valid;
  logic                  r_rd_fire;
  bank_e                 r_rd_bank;
  logic [DATA_WIDTH-1:0] r_rd_hold;
  logic                  r_err_oob;

  logic [AW-1:0]         w_wr_addr;
  logic [AW-1:0]         w_rd_addr;
  logic                  w_wr_oob;
  logic                  w_rd_oob;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_commit;
  logic                  w_release;
  logic                  w_we_a;
  logic                  w_we_b;
  logic                  w_re_a;
  logic                  w_re_b;
  logic [1:0]            w_bank_full_nxt;
  logic [DATA_WIDTH-1:0] w_q_a;
  logic [DATA_WIDTH-1:0] w_q_b;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // Operands are widened before multiplying so the full address survives.
  assign w_wr_addr = AW'(wr_ch) * CH_STRIDE + AW'(wr_h) * ROW_STRIDE + AW'(wr_w);
  assign w_rd_addr = AW'(rd_ch) * CH_STRIDE + AW'(rd_h) * ROW_STRIDE + AW'(rd_w);

  assign w_wr_oob = (int'(wr_ch) >= OUT_C) || (int'(wr_h) >= OUT_H) || (int'(wr_w) >= OUT_W);
  assign w_rd_oob = (int'(rd_ch) >= OUT_C) || (int'(rd_h) >= OUT_H) || (int'(rd_w) >= OUT_W);

  // Handshake: a write transfers on the edge where wr_valid && wr_ready; reads
  // and releases are only honoured while rd_avail, otherwise silently dropped.
  assign wr_ready  = !r_bank_full[r_sel.wr_sel];
  assign rd_avail  = r_bank_full[r_sel.rd_sel];
  assign w_wr_acc  = wr_valid && wr_ready;
  assign w_rd_acc  = rd_en && rd_avail;
  assign w_commit  = w_wr_acc && wr_last;
  assign w_release = rd_done && rd_avail;

  assign w_we_a = w_wr_acc && !w_wr_oob && (r_sel.wr_sel == BANK_A);
  assign w_we_b = w_wr_acc && !w_wr_oob && (r_sel.wr_sel == BANK_B);
  assign w_re_a = w_rd_acc && !w_rd_oob && (r_sel.rd_sel == BANK_A);
  assign w_re_b = w_rd_acc && !w_rd_oob && (r_sel.rd_sel == BANK_B);

  // Commit and release can coincide; they never hit the same bank.
  always_comb begin
    w_bank_full_nxt = r_bank_full;
    if (w_commit)  w_bank_full_nxt[r_sel.wr_sel] = 1'b1;
    if (w_release) w_bank_full_nxt[r_sel.rd_sel] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel       <= '{rd_sel: BANK_A, wr_sel: BANK_A};
      r_bank_full <= 2'b00;
      r_rd_valid  <= 1'b0;
      r_rd_fire   <= 1'b0;
      r_rd_bank   <= BANK_A;
      r_rd_hold   <= '0;
      r_err_oob   <= 1'b0;
    end else begin
      r_bank_full <= w_bank_full_nxt;
      if (w_commit)  r_sel.wr_sel <= bank_e'(~r_sel.wr_sel);
      if (w_release) r_sel.rd_sel <= bank_e'(~r_sel.rd_sel);
      r_rd_valid <= w_rd_acc;
      r_rd_fire  <= w_rd_acc && !w_rd_oob;
      r_rd_bank  <= r_sel.rd_sel;
      r_rd_hold  <= w_rd_data;
      if ((w_wr_acc && w_wr_oob) || (w_rd_acc && w_rd_oob)) r_err_oob <= 1'b1;
    end
  end

  // Outside a real read the last delivered value is replayed from r_rd_hold.
  assign w_rd_data = r_rd_fire ? ((r_rd_bank == BANK_B) ? w_q_b : w_q_a) : r_rd_hold;

  assign rd_data   = w_rd_data;
  assign rd_valid  = r_rd_valid;
  assign bank_full = r_bank_full;
  assign err_oob   = r_err_oob;

  fmap_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .AW        (AW)
  ) u_bank_a (
    .clk    (clk),
    .i_we   (w_we_a),
    .i_waddr(w_wr_addr),
    .i_wdata(wr_data),
    .i_re   (w_re_a),
    .i_raddr(w_rd_addr),
    .o_rdata(w_q_a)
  );

  fmap_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .AW        (AW)
  ) u_bank_b (
    .clk    (clk),
    .i_we   (w_we_b),
    .i_waddr(w_wr_addr),
    .i_wdata(wr_data),
    .i_re   (w_re_b),
    .i_raddr(w_rd_addr),
    .o_rdata(w_q_b)
  );

endmodule

// File: tb/tb_pingpong_fmap_buffer.sv
// Directed bench for pingpong_fmap_buffer: a default-sized instance for the
// bank-swap protocol and a 2x60x4 instance for full fill, range errors and reset.
module tb_pingpong_fmap_buffer;

  logic clk;

  // default-parameter instance (16 x 64 x 64)
  logic       d_rst, d_wr_valid, d_wr_ready, d_wr_last, d_rd_en, d_rd_done;
  logic       d_rd_avail, d_rd_valid, d_err_oob;
  logic [7:0] d_wr_data, d_rd_data;
  logic [3:0] d_wr_ch, d_rd_ch;
  logic [5:0] d_wr_h, d_wr_w, d_rd_h, d_rd_w;
  logic [1:0] d_bank_full;

  // small instance (2 x 60 x 4)
  logic       s_rst, s_wr_valid, s_wr_ready, s_wr_last, s_rd_en, s_rd_done;
  logic       s_rd_avail, s_rd_valid, s_err_oob;
  logic [7:0] s_wr_data, s_rd_data;
  logic [0:0] s_wr_ch, s_rd_ch;
  logic [5:0] s_wr_h, s_rd_h;
  logic [1:0] s_wr_w, s_rd_w;
  logic [1:0] s_bank_full;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  pingpong_fmap_buffer u_def (
    .clk(clk), .rst(d_rst),
    .wr_valid(d_wr_valid), .wr_ready(d_wr_ready), .wr_data(d_wr_data),
    .wr_ch(d_wr_ch), .wr_h(d_wr_h), .wr_w(d_wr_w), .wr_last(d_wr_last),
    .rd_en(d_rd_en), .rd_ch(d_rd_ch), .rd_h(d_rd_h), .rd_w(d_rd_w),
    .rd_done(d_rd_done), .rd_avail(d_rd_avail), .rd_valid(d_rd_valid),
    .rd_data(d_rd_data), .bank_full(d_bank_full), .err_oob(d_err_oob)
  );

  pingpong_fmap_buffer #(.DATA_WIDTH(8), .OUT_H(60), .OUT_W(4), .OUT_C(2)) u_s (
    .clk(clk), .rst(s_rst),
    .wr_valid(s_wr_valid), .wr_ready(s_wr_ready), .wr_data(s_wr_data),
    .wr_ch(s_wr_ch), .wr_h(s_wr_h), .wr_w(s_wr_w), .wr_last(s_wr_last),
    .rd_en(s_rd_en), .rd_ch(s_rd_ch), .rd_h(s_rd_h), .rd_w(s_rd_w),
    .rd_done(s_rd_done), .rd_avail(s_rd_avail), .rd_valid(s_rd_valid),
    .rd_data(s_rd_data), .bank_full(s_bank_full), .err_oob(s_err_oob)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rd_d(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    check(tag, {24'd0, d_rd_data}, {24'd0, e});
  endtask

  task automatic check_rd_s(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    check(tag, {24'd0, s_rd_data}, {24'd0, e});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drivers
  task automatic d_wr(input int ch, input int h, input int w, input logic [7:0] data, input logic last);
    d_wr_valid = 1'b1; d_wr_ch = 4'(ch); d_wr_h = 6'(h); d_wr_w = 6'(w);
    d_wr_data = data; d_wr_last = last;
    step();
    d_wr_valid = 1'b0; d_wr_last = 1'b0;
  endtask

  task automatic d_rd(input int ch, input int h, input int w, input logic done);
    d_rd_en = 1'b1; d_rd_ch = 4'(ch); d_rd_h = 6'(h); d_rd_w = 6'(w); d_rd_done = done;
    step();
    d_rd_en = 1'b0; d_rd_done = 1'b0;
  endtask

  task automatic s_wr(input int ch, input int h, input int w, input logic [7:0] data, input logic last);
    s_wr_valid = 1'b1; s_wr_ch = 1'(ch); s_wr_h = 6'(h); s_wr_w = 2'(w);
    s_wr_data = data; s_wr_last = last;
    step();
    s_wr_valid = 1'b0; s_wr_last = 1'b0;
  endtask

  task automatic s_rd(input int ch, input int h, input int w, input logic done);
    s_rd_en = 1'b1; s_rd_ch = 1'(ch); s_rd_h = 6'(h); s_rd_w = 2'(w); s_rd_done = done;
    step();
    s_rd_en = 1'b0; s_rd_done = 1'b0;
  endtask

  initial begin
    d_rst = 1'b0; d_wr_valid = 0; d_wr_last = 0; d_rd_en = 0; d_rd_done = 0;
    d_wr_data = '0; d_wr_ch = '0; d_wr_h = '0; d_wr_w = '0; d_rd_ch = '0; d_rd_h = '0; d_rd_w = '0;
    s_rst = 1'b0; s_wr_valid = 0; s_wr_last = 0; s_rd_en = 0; s_rd_done = 0;
    s_wr_data = '0; s_wr_ch = '0; s_wr_h = '0; s_wr_w = '0; s_rd_ch = '0; s_rd_h = '0; s_rd_w = '0;
    #3;
    check("rst_wr_ready", {31'd0, d_wr_ready}, 32'd1);
    check("rst_rd_avail", {31'd0, d_rd_avail}, 32'd0);
    check("rst_bank_full", {30'd0, d_bank_full}, 32'd0);
    check("rst_rd_valid", {31'd0, d_rd_valid}, 32'd0);
    check("rst_rd_data", {24'd0, d_rd_data}, 32'd0);
    check("rst_err_oob", {31'd0, d_err_oob}, 32'd0);
    check("rst_s_wr_ready", {31'd0, s_wr_ready}, 32'd1);
    @(negedge clk);
    d_rst = 1'b1; s_rst = 1'b1;
    step();

    // ---- default instance: commit, read, stall, release, swap ----
    d_wr(1, 2, 3, 8'hA5, 1'b0);
    d_wr(0, 0, 0, 8'h11, 1'b0);
    check("partial_bank_full", {30'd0, d_bank_full}, 32'd0);
    d_wr(15, 63, 63, 8'h3C, 1'b1);
    check("commitA_bank_full", {30'd0, d_bank_full}, 32'h1);
    check("commitA_rd_avail", {31'd0, d_rd_avail}, 32'd1);
    check("commitA_wr_ready", {31'd0, d_wr_ready}, 32'd1);
    check("commitA_wr_sel", {31'd0, u_def.r_sel.wr_sel}, 32'd1);
    check("addr_4227", {24'd0, u_def.u_bank_a.r_mem[4227]}, 32'hA5);

    exp_q.push_back(8'hA5);
    d_rd(1, 2, 3, 1'b0);
    check("rd123_valid", {31'd0, d_rd_valid}, 32'd1);
    check_rd_d("rd123_data");
    exp_q.push_back(8'h3C);
    d_rd(15, 63, 63, 1'b0);
    check_rd_d("rd_corner_data");
    exp_q.push_back(8'h11);
    d_rd(0, 0, 0, 1'b0);
    check_rd_d("rd000_data");
    step();
    check("idle_rd_valid", {31'd0, d_rd_valid}, 32'd0);
    check("idle_rd_hold", {24'd0, d_rd_data}, 32'h11);

    d_wr(2, 0, 0, 8'h77, 1'b1);
    check("both_full", {30'd0, d_bank_full}, 32'h3);
    check("both_full_wr_ready", {31'd0, d_wr_ready}, 32'd0);
    d_wr(1, 2, 3, 8'hEE, 1'b1);
    check("stall_bank_full", {30'd0, d_bank_full}, 32'h3);
    check("stall_wr_sel", {31'd0, u_def.r_sel.wr_sel}, 32'd0);
    check("stall_memA", {24'd0, u_def.u_bank_a.r_mem[4227]}, 32'hA5);
    check("memB_8192", {24'd0, u_def.u_bank_b.r_mem[8192]}, 32'h77);

    exp_q.push_back(8'h11);
    d_rd(0, 0, 0, 1'b1);
    check("rel_rd_valid", {31'd0, d_rd_valid}, 32'd1);
    check_rd_d("rel_rd_data");
    check("relA_bank_full", {30'd0, d_bank_full}, 32'h2);
    check("relA_wr_ready", {31'd0, d_wr_ready}, 32'd1);
    check("relA_rd_sel", {31'd0, u_def.r_sel.rd_sel}, 32'd1);

    exp_q.push_back(8'h77);
    d_rd(2, 0, 0, 1'b1);
    check_rd_d("relB_rd_data");
    check("relB_bank_full", {30'd0, d_bank_full}, 32'h0);
    check("relB_rd_avail", {31'd0, d_rd_avail}, 32'd0);

    d_rd(0, 0, 0, 1'b1);
    check("noavail_rd_valid", {31'd0, d_rd_valid}, 32'd0);
    check("noavail_rd_hold", {24'd0, d_rd_data}, 32'h77);
    check("noavail_rd_sel", {31'd0, u_def.r_sel.rd_sel}, 32'd0);

    d_wr(0, 0, 1, 8'h22, 1'b1);
    check("commitA2_bank_full", {30'd0, d_bank_full}, 32'h1);
    // commit B and release A on the same edge
    d_wr_valid = 1'b1; d_wr_ch = 4'd0; d_wr_h = 6'd0; d_wr_w = 6'd2; d_wr_data = 8'h33;
    d_wr_last = 1'b1; d_rd_done = 1'b1;
    step();
    d_wr_valid = 1'b0; d_wr_last = 1'b0; d_rd_done = 1'b0;
    check("swap_bank_full", {30'd0, d_bank_full}, 32'h2);
    check("swap_rd_sel", {31'd0, u_def.r_sel.rd_sel}, 32'd1);
    check("swap_wr_sel", {31'd0, u_def.r_sel.wr_sel}, 32'd0);
    exp_q.push_back(8'h33);
    d_rd(0, 0, 2, 1'b0);
    check_rd_d("swap_rd_data");

    // ---- small instance: full fill, out-of-range, async reset ----
    for (int a = 0; a < 480; a++) begin
      s_wr(a / 240, (a % 240) / 4, a % 4, 8'(a), a == 479);
      if (a == 478) check("fill_before_last", {30'd0, s_bank_full}, 32'h0);
    end
    check("fill_bank_full", {30'd0, s_bank_full}, 32'h1);
    check("fill_rd_avail", {31'd0, s_rd_avail}, 32'd1);
    check("fill_wr_sel", {31'd0, u_s.r_sel.wr_sel}, 32'd1);
    check("fill_mem479", {24'd0, u_s.u_bank_a.r_mem[479]}, 32'hDF);
    exp_q.push_back(8'hDF);
    s_rd(1, 59, 3, 1'b0);
    check_rd_s("fill_rd_1_59_3");
    exp_q.push_back(8'h06);
    s_rd(0, 1, 2, 1'b0);
    check_rd_s("fill_rd_0_1_2");

    s_wr(1, 0, 0, 8'h55, 1'b0);
    check("pre_oob_err", {31'd0, s_err_oob}, 32'd0);
    s_wr(0, 60, 0, 8'h99, 1'b0);
    check("oob_wr_err", {31'd0, s_err_oob}, 32'd1);
    check("oob_wr_mem", {24'd0, u_s.u_bank_b.r_mem[240]}, 32'h55);
    s_wr(0, 0, 0, 8'h12, 1'b0);
    step();
    check("oob_sticky", {31'd0, s_err_oob}, 32'd1);
    s_rd(0, 60, 0, 1'b0);
    check("oob_rd_valid", {31'd0, s_rd_valid}, 32'd1);
    check("oob_rd_hold", {24'd0, s_rd_data}, 32'h06);
    exp_q.push_back(8'h01);
    s_rd(0, 0, 1, 1'b0);
    check_rd_s("pre_rst_rd");

    // mid-cycle reset, sampled before the next edge
    s_rst = 1'b0; d_rst = 1'b0;
    #1;
    check("arst_rd_valid", {31'd0, s_rd_valid}, 32'd0);
    check("arst_rd_data", {24'd0, s_rd_data}, 32'd0);
    check("arst_bank_full", {30'd0, s_bank_full}, 32'd0);
    check("arst_err_oob", {31'd0, s_err_oob}, 32'd0);
    check("arst_wr_ready", {31'd0, s_wr_ready}, 32'd1);
    check("arst_rd_avail", {31'd0, s_rd_avail}, 32'd0);
    check("arst_d_bank_full", {30'd0, d_bank_full}, 32'd0);
    check("arst_d_rd_sel", {31'd0, u_def.r_sel.rd_sel}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
